key_extract: RTL and testbench
==============================

Name: key_extract

Overview:
- Per-stage key extractor in the RMT match-action pipeline; one instance per stage, selected by parameter STAGE.
- Takes a PHV and builds a match key from six configurable containers: two 48b, two 32b and two 16b.
- Appends a 5-bit predicate from this stage's comparator field in the PHV.
- Forwards the PHV unchanged, aligned with the key.

Parameters:
- STAGE, 0, stage index 0..4; selects this stage's 20b comparator slice.
- PHV_LEN, 1124, PHV width (8x48 + 8x32 + 8x16 + 5x20 + 256).
- KEY_LEN, 197, key width (2x48 + 2x32 + 2x16 + 5).
- KEY_OFF, 18, offset-config width (six 3b container indices).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- phv_in  in  PHV_LEN  input PHV.
- phv_valid_in  in  1  phv_in valid.
- key_offset_in  in  KEY_OFF  {i48a, i48b, i32a, i32b, i16a, i16b}, MSB first.
- key_offset_valid_in  in  1  load key_offset_in into the offset register.
- phv_out  out  PHV_LEN  registered copy of phv_in.
- phv_valid_out  out  1  phv_out valid.
- key_out  out  KEY_LEN  extracted key.
- key_valid_out  out  1  key_out valid.

Behaviour:
- Reset: all outputs and the offset register clear to 0.
- PHV layout, MSB to LSB; container n in each group, with 7 the highest-order:
  - [1123:740] 8x48b containers.
  - [739:484] 8x32b containers.
  - [483:356] 8x16b containers.
  - [355:256] comparator region: 5x20b slices; stage s uses [355-20s -: 20].
  - [255:0] metadata.
- Offset register: loads on key_offset_valid_in. A PHV arriving in the same cycle uses the old value (register-before-use). No other writes.
- Key: key_out = {C48[i48a], C48[i48b], C32[i32a], C32[i32b], C16[i16a], C16[i16b], pred[4:0]}.
- Comparator slice {op[1:0], opA[8:0], opB[8:0]}.
- Operand fields:
  - bit8 = immediate flag; bits[7:5] unused when the flag is 0.
  - If immediate: value = bits[7:0], zero-extended to 16b.
  - Else: bits[4:3] select the group (00=16b, 01=32b, 10=48b, 11=value 0); bits[2:0] = container index; value = low 16 bits of that container.
- Ops, unsigned: 00 A>B, 01 A>=B, 10 A==B, 11 always true.
- pred = {4'b0, result}.
- Latency: exactly 1 cycle, fully pipelined, one PHV per cycle, no back-pressure.
- phv_valid_out = key_valid_out = phv_valid_in delayed one cycle.
- Data on an invalid cycle: phv_out and key_out register regardless of valid; consumers qualify with the valid outputs.
- Reset mid-stream: in-flight PHV dropped, valids 0 next cycle, offsets return to 0 (container 0 of each group).

Decomposition:
- Shared package: container widths and counts, field bit-offsets, comparator slice width (20), op encodings, group-select encodings, derived PHV_LEN and KEY_LEN.
- One natural sub-module: key_cmp (combinational operand fetch and compare, producing pred).

Test Plan:
- Reset: assert rst for 1 cycle -> all outputs 0; a PHV sent next with no offset write extracts container 0 of each group.
- Offset swap: load {6,7,6,7,6,7}, then PHV with C48[7]=ffffffffffff, C48[6]=eeeeeeeeeeee, C32[7]=cccccccc, C32[6]=bbbbbbbb, C16[7]=ffff, C16[6]=eeee, comparator zero -> after 1 cycle key_out = {eeee..,ffff..,bbbbbbbb,cccccccc,eeee,ffff,5'b00000}, valids high 1 cycle, phv_out == phv_in.
- Comparator: same PHV with stage-0 slice {2'b00, 9'b0000_10_111, 9'b0000_10_110} -> ffff > eeee, pred = 5'b00001.
- Operand types: immediate operands (opA imm 0x10, opB imm 0x10) with op 10 -> pred bit0 = 1; op 00 -> 0; op 11 -> 1.
- Same-cycle config and PHV: new offsets with a PHV in the same cycle -> key uses old offsets; the next PHV uses the new ones.
- Throughput and STAGE: back-to-back PHVs for 4 cycles -> 4 consecutive valid outputs at 1-cycle latency; STAGE=2 instance reads slice [315:296] only.

Source files
------------

// File: rtl/key_extract_pkg.sv
// Shared layout constants and encodings for the per-stage key extractor.
package key_extract_pkg;

   localparam int W48     = 48;
   localparam int W32     = 32;
   localparam int W16     = 16;
   localparam int N_CONT  = 8;
   localparam int N_GRP   = 3;
   localparam int N_STAGE = 5;
   localparam int CMP_W   = 20;
   localparam int META_W  = 256;
   localparam int PRED_W  = 5;
   localparam int IDX_W   = 3;

   // Bit offsets of container 0 in each group; container n sits n widths above.
   localparam int C16_BASE = META_W + N_STAGE * CMP_W;
   localparam int C32_BASE = C16_BASE + N_CONT * W16;
   localparam int C48_BASE = C32_BASE + N_CONT * W32;
   localparam int CMP_TOP  = C16_BASE - 1;

   localparam int PHV_LEN_C = C48_BASE + N_CONT * W48;
   localparam int KEY_LEN_C = 2 * (W48 + W32 + W16) + PRED_W;
   localparam int KEY_OFF_C = 6 * IDX_W;

   // Low 16 bits of every container, grouped in the same order as grp_sel_e.
   localparam int LOW_W = N_GRP * N_CONT * W16;

   // Operand field layout inside a 9-bit comparator operand.
   localparam int IMM_BIT = 8;

   typedef enum logic [1:0] {
      OP_GT   = 2'b00,
      OP_GE   = 2'b01,
      OP_EQ   = 2'b10,
      OP_TRUE = 2'b11
   } cmp_op_e;

   typedef enum logic [1:0] {
      GRP_16   = 2'b00,
      GRP_32   = 2'b01,
      GRP_48   = 2'b10,
      GRP_ZERO = 2'b11
   } grp_sel_e;

endpackage

// File: rtl/key_extract_cmp.sv
// Combinational operand fetch and compare producing this stage's predicate.
module key_cmp
   import key_extract_pkg::*;
(
   input  logic [LOW_W-1:0]  low_halves,
   input  logic [CMP_W-1:0]  cmp_slice,
   output logic [PRED_W-1:0] pred
);

   // Resolve an operand to a 16-bit value: immediate, container low half, or zero.
   function automatic logic [15:0] operand_value(input logic [8:0] fld,
                                                 input logic [LOW_W-1:0] lows);
      logic [15:0] v;
      grp_sel_e    grp;
      v   = '0;
      grp = grp_sel_e'(fld[4:3]);
      if (fld[IMM_BIT]) begin
         v = {8'h00, fld[7:0]};
      end else if (grp != GRP_ZERO) begin
         v = lows[(int'(fld[4:3]) * N_CONT + int'(fld[2:0])) * W16 +: W16];
      end
      return v;
   endfunction

   logic [15:0] val_a;
   logic [15:0] val_b;
   cmp_op_e     op;
   logic        result;

   // Fetch both operands and apply the unsigned comparison selected by op.
   always_comb begin
      val_a  = operand_value(cmp_slice[17:9], low_halves);
      val_b  = operand_value(cmp_slice[8:0], low_halves);
      op     = cmp_op_e'(cmp_slice[19:18]);
      result = 1'b0;
      case (op)
         OP_GT:   result = (val_a > val_b);
         OP_GE:   result = (val_a >= val_b);
         OP_EQ:   result = (val_a == val_b);
         OP_TRUE: result = 1'b1;
         default: result = 1'b0;
      endcase
      pred = {4'b0000, result};
   end

endmodule

// File: rtl/key_extract.sv
// Per-stage match-key extractor: picks six containers plus a predicate and
// forwards the PHV alongside the key with one cycle of latency.
module key_extract
   import key_extract_pkg::*;
#(
   parameter int STAGE   = 0,
   parameter int PHV_LEN = PHV_LEN_C,
   parameter int KEY_LEN = KEY_LEN_C,
   parameter int KEY_OFF = KEY_OFF_C
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PHV_LEN-1:0] phv_in,
   input  logic               phv_valid_in,
   input  logic [KEY_OFF-1:0] key_offset_in,
   input  logic               key_offset_valid_in,
   output logic [PHV_LEN-1:0] phv_out,
   output logic               phv_valid_out,
   output logic [KEY_LEN-1:0] key_out,
   output logic               key_valid_out
);

   logic [KEY_OFF-1:0] offset_q;
   logic [LOW_W-1:0]   low_halves;
   logic [CMP_W-1:0]   cmp_slice;
   logic [PRED_W-1:0]  pred;
   logic [KEY_LEN-1:0] key_next;
   logic [IDX_W-1:0]   i48a, i48b, i32a, i32b, i16a, i16b;

   assign {i48a, i48b, i32a, i32b, i16a, i16b} = offset_q;
   assign cmp_slice = phv_in[CMP_TOP - CMP_W * STAGE -: CMP_W];

   // Offset register; a PHV in the load cycle still sees the previous value.
   always_ff @(posedge clk) begin
      if (rst) begin
         offset_q <= '0;
      end else if (key_offset_valid_in) begin
         offset_q <= key_offset_in;
      end
   end

   // Gather the low half of every container for the comparator operand mux.
   always_comb begin
      low_halves = '0;
      for (int n = 0; n < N_CONT; n++) begin
         low_halves[(0 * N_CONT + n) * W16 +: W16] = phv_in[C16_BASE + W16 * n +: W16];
         low_halves[(1 * N_CONT + n) * W16 +: W16] = phv_in[C32_BASE + W32 * n +: W16];
         low_halves[(2 * N_CONT + n) * W16 +: W16] = phv_in[C48_BASE + W48 * n +: W16];
      end
   end

   key_cmp u_cmp (
      .low_halves (low_halves),
      .cmp_slice  (cmp_slice),
      .pred       (pred)
   );

   // Assemble the key from the selected containers and the predicate.
   always_comb begin
      key_next = {phv_in[C48_BASE + W48 * int'(i48a) +: W48],
                  phv_in[C48_BASE + W48 * int'(i48b) +: W48],
                  phv_in[C32_BASE + W32 * int'(i32a) +: W32],
                  phv_in[C32_BASE + W32 * int'(i32b) +: W32],
                  phv_in[C16_BASE + W16 * int'(i16a) +: W16],
                  phv_in[C16_BASE + W16 * int'(i16b) +: W16],
                  pred};
   end

   // Output stage: data registers every cycle, valids qualify it.
   always_ff @(posedge clk) begin
      if (rst) begin
         phv_out       <= '0;
         phv_valid_out <= 1'b0;
         key_out       <= '0;
         key_valid_out <= 1'b0;
      end else begin
         phv_out       <= phv_in;
         phv_valid_out <= phv_valid_in;
         key_out       <= key_next;
         key_valid_out <= phv_valid_in;
      end
   end

endmodule

// File: tb/tb_key_extract.sv
// Directed self-checking bench for key_extract (stage 0 and stage 2 instances).
module tb_key_extract;

   localparam int PL = 1124;
   localparam int KL = 197;

   logic          clk;
   logic          rst;
   logic [PL-1:0] phv_in;
   logic          phv_valid_in;
   logic [17:0]   key_offset_in;
   logic          key_offset_valid_in;

   logic [PL-1:0] phv_out0, phv_out2;
   logic          phv_valid_out0, phv_valid_out2;
   logic [KL-1:0] key_out0, key_out2;
   logic          key_valid_out0, key_valid_out2;

   int test_count = 0;
   int fail_count = 0;

   key_extract #(.STAGE(0)) u_stage0 (
      .clk                 (clk),
      .rst                 (rst),
      .phv_in              (phv_in),
      .phv_valid_in        (phv_valid_in),
      .key_offset_in       (key_offset_in),
      .key_offset_valid_in (key_offset_valid_in),
      .phv_out             (phv_out0),
      .phv_valid_out       (phv_valid_out0),
      .key_out             (key_out0),
      .key_valid_out       (key_valid_out0)
   );

   key_extract #(.STAGE(2)) u_stage2 (
      .clk                 (clk),
      .rst                 (rst),
      .phv_in              (phv_in),
      .phv_valid_in        (phv_valid_in),
      .key_offset_in       (key_offset_in),
      .key_offset_valid_in (key_offset_valid_in),
      .phv_out             (phv_out2),
      .phv_valid_out       (phv_valid_out2),
      .key_out             (key_out2),
      .key_valid_out       (key_valid_out2)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [PL-1:0] put48(input logic [PL-1:0] p, input int n, input logic [47:0] v);
      p[740 + 48 * n +: 48] = v;
      return p;
   endfunction

   function automatic logic [PL-1:0] put32(input logic [PL-1:0] p, input int n, input logic [31:0] v);
      p[484 + 32 * n +: 32] = v;
      return p;
   endfunction

   function automatic logic [PL-1:0] put16(input logic [PL-1:0] p, input int n, input logic [15:0] v);
      p[356 + 16 * n +: 16] = v;
      return p;
   endfunction

   function automatic logic [PL-1:0] put_cmp(input logic [PL-1:0] p, input int s, input logic [19:0] v);
      p[355 - 20 * s -: 20] = v;
      return p;
   endfunction

   // Base PHV: C48[n]=4848_0000_000n, C32[n]=3232_000n, C16[n]=160n, comparators zero.
   function automatic logic [PL-1:0] base_phv();
      logic [PL-1:0] p;
      p = '0;
      for (int n = 0; n < 8; n++) begin
         p = put48(p, n, 48'h4848_0000_0000 + 48'(n));
         p = put32(p, n, 32'h3232_0000 + 32'(n));
         p = put16(p, n, 16'h1600 + 16'(n));
      end
      p[255:0] = {8{32'hDEAD_BEEF}};
      return p;
   endfunction

   function automatic logic [KL-1:0] mk_key(input logic [47:0] a48, input logic [47:0] b48,
                                            input logic [31:0] a32, input logic [31:0] b32,
                                            input logic [15:0] a16, input logic [15:0] b16,
                                            input logic [4:0] pr);
      return {a48, b48, a32, b32, a16, b16, pr};
   endfunction

   task automatic applyStimulus(input logic [PL-1:0] p, input logic pv,
                                input logic [17:0] off, input logic ov, input logic r);
      @(negedge clk);
      phv_in              = p;
      phv_valid_in        = pv;
      key_offset_in       = off;
      key_offset_valid_in = ov;
      rst                 = r;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      test_count++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   logic [PL-1:0] base;
   logic [PL-1:0] swap;
   logic [PL-1:0] p;
   logic [17:0]   off_swap;
   logic [17:0]   off_seq;

   initial begin
      base     = base_phv();
      off_swap = {3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7};
      off_seq  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

      swap = base;
      swap = put48(swap, 7, 48'hffff_ffff_ffff);
      swap = put48(swap, 6, 48'heeee_eeee_eeee);
      swap = put32(swap, 7, 32'hcccc_cccc);
      swap = put32(swap, 6, 32'hbbbb_bbbb);
      swap = put16(swap, 7, 16'hffff);
      swap = put16(swap, 6, 16'heeee);

      // Reset held for two edges with a valid PHV and offset write: all must stay 0.
      phv_in = base; phv_valid_in = 1'b1; key_offset_in = off_swap; key_offset_valid_in = 1'b1; rst = 1'b1;
      stepCycle();
      stepCycle();
      checkOutput("rst_phv_valid", 256'(phv_valid_out0), 256'd0);
      checkOutput("rst_key_valid", 256'(key_valid_out0), 256'd0);
      checkOutput("rst_key", 256'(key_out0), 256'd0);
      checkOutput("rst_phv_zero", 256'(phv_out0 === '0), 256'd1);

      // First PHV after reset uses container 0 of each group.
      applyStimulus(base, 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("post_rst_key", 256'(key_out0),
                  256'(mk_key(48'h4848_0000_0000, 48'h4848_0000_0000, 32'h3232_0000, 32'h3232_0000,
                              16'h1600, 16'h1600, 5'd0)));
      checkOutput("post_rst_valid", 256'({phv_valid_out0, key_valid_out0}), 256'd3);
      checkOutput("post_rst_phv", 256'(phv_out0 === base), 256'd1);

      // Load swapped offsets with no PHV, then send the swap PHV.
      applyStimulus(base, 1'b0, off_swap, 1'b1, 1'b0);
      stepCycle();
      checkOutput("cfg_only_valid", 256'(key_valid_out0), 256'd0);
      applyStimulus(swap, 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("swap_key", 256'(key_out0),
                  256'(mk_key(48'heeee_eeee_eeee, 48'hffff_ffff_ffff, 32'hbbbb_bbbb, 32'hcccc_cccc,
                              16'heeee, 16'hffff, 5'd0)));
      checkOutput("swap_valid", 256'({phv_valid_out0, key_valid_out0}), 256'd3);
      checkOutput("swap_phv", 256'(phv_out0 === swap), 256'd1);
      applyStimulus(swap, 1'b0, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("swap_valid_drop", 256'({phv_valid_out0, key_valid_out0}), 256'd0);

      // Comparator: C48[7] low ffff > C48[6] low eeee.
      applyStimulus(put_cmp(swap, 0, {2'b00, 9'b0_000_10_111, 9'b0_000_10_110}), 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("cmp_48_gt", 256'(key_out0[4:0]), 256'd1);
      // Reversed operands: eeee > ffff is false.
      applyStimulus(put_cmp(swap, 0, {2'b00, 9'b0_000_10_110, 9'b0_000_10_111}), 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("cmp_48_gt_rev", 256'(key_out0[4:0]), 256'd0);

      // Immediate operands 0x10 vs 0x10 under each op.
      applyStimulus(put_cmp(swap, 0, {2'b10, 9'h110, 9'h110}), 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("imm_eq", 256'(key_out0[4:0]), 256'd1);
      applyStimulus(put_cmp(swap, 0, {2'b00, 9'h110, 9'h110}), 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("imm_gt", 256'(key_out0[4:0]), 256'd0);
      applyStimulus(put_cmp(swap, 0, {2'b11, 9'h110, 9'h110}), 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("imm_true", 256'(key_out0[4:0]), 256'd1);
      applyStimulus(put_cmp(swap, 0, {2'b01, 9'h110, 9'h111}), 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("imm_ge_less", 256'(key_out0[4:0]), 256'd0);
      applyStimulus(put_cmp(swap, 0, {2'b01, 9'h110, 9'h110}), 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("imm_ge_equal", 256'(key_out0[4:0]), 256'd1);
      // Group 11 reads as zero, equal to immediate 0.
      applyStimulus(put_cmp(swap, 0, {2'b10, 9'b0_000_11_101, 9'h100}), 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("grp_zero_eq", 256'(key_out0[4:0]), 256'd1);
      // C32[7] low cccc > imm ff.
      applyStimulus(put_cmp(swap, 0, {2'b00, 9'b0_000_01_111, 9'h1ff}), 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("grp32_gt_imm", 256'(key_out0[4:0]), 256'd1);
      // C16[5]=1605 == C16[5] with unused bits set in opA.
      applyStimulus(put_cmp(base, 0, {2'b10, 9'b0_111_00_101, 9'b0_000_00_101}), 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("grp16_unused_bits", 256'(key_out0[4:0]), 256'd1);

      // New offsets with a PHV in the same cycle: key still uses {6,7,6,7,6,7}.
      applyStimulus(base, 1'b1, off_seq, 1'b1, 1'b0);
      stepCycle();
      checkOutput("same_cycle_old", 256'(key_out0),
                  256'(mk_key(48'h4848_0000_0006, 48'h4848_0000_0007, 32'h3232_0006, 32'h3232_0007,
                              16'h1606, 16'h1607, 5'd0)));

      // Back-to-back PHVs under the new offsets, predicate toggling.
      for (int k = 0; k < 4; k++) begin
         p = put48(base, 0, 48'h0000_1111_0000 + 48'(k));
         p = put_cmp(p, 0, (k % 2 == 1) ? {2'b11, 18'd0} : 20'd0);
         applyStimulus(p, 1'b1, '0, 1'b0, 1'b0);
         stepCycle();
         checkOutput($sformatf("b2b_valid%0d", k), 256'({phv_valid_out0, key_valid_out0}), 256'd3);
         checkOutput($sformatf("b2b_key%0d", k), 256'(key_out0),
                     256'(mk_key(48'h0000_1111_0000 + 48'(k), 48'h4848_0000_0001, 32'h3232_0002,
                                 32'h3232_0003, 16'h1604, 16'h1605, 5'(k % 2))));
      end

      // Invalid cycle: data still registers, valids low.
      p = put16(base, 5, 16'h5a5a);
      applyStimulus(p, 1'b0, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("inv_valid", 256'({phv_valid_out0, key_valid_out0}), 256'd0);
      checkOutput("inv_key", 256'(key_out0),
                  256'(mk_key(48'h4848_0000_0000, 48'h4848_0000_0001, 32'h3232_0002, 32'h3232_0003,
                              16'h1604, 16'h5a5a, 5'd0)));
      checkOutput("inv_phv", 256'(phv_out0 === p), 256'd1);

      // Stage selection: only slice [315:296] drives the stage-2 predicate.
      p = put_cmp(base, 0, {2'b00, 9'h100, 9'h100});
      p = put_cmp(p, 1, {2'b00, 9'h100, 9'h100});
      p = put_cmp(p, 2, {2'b11, 18'd0});
      p = put_cmp(p, 3, {2'b00, 9'h100, 9'h100});
      p = put_cmp(p, 4, {2'b00, 9'h100, 9'h100});
      applyStimulus(p, 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("stage2_true", 256'(key_out2[4:0]), 256'd1);
      checkOutput("stage0_false", 256'(key_out0[4:0]), 256'd0);
      p = put_cmp(base, 0, {2'b11, 18'd0});
      p = put_cmp(p, 1, {2'b11, 18'd0});
      p = put_cmp(p, 2, {2'b00, 9'h100, 9'h100});
      p = put_cmp(p, 3, {2'b11, 18'd0});
      p = put_cmp(p, 4, {2'b11, 18'd0});
      applyStimulus(p, 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("stage2_false", 256'(key_out2[4:0]), 256'd0);
      checkOutput("stage0_true", 256'(key_out0[4:0]), 256'd1);
      checkOutput("stage2_valid", 256'(key_valid_out2), 256'd1);

      // Reset mid-stream drops the in-flight PHV and clears the offsets.
      applyStimulus(swap, 1'b1, '0, 1'b0, 1'b1);
      stepCycle();
      checkOutput("mid_rst_valid", 256'({phv_valid_out0, key_valid_out0}), 256'd0);
      checkOutput("mid_rst_key", 256'(key_out0), 256'd0);
      applyStimulus(swap, 1'b1, '0, 1'b0, 1'b0);
      stepCycle();
      checkOutput("mid_rst_offsets", 256'(key_out0),
                  256'(mk_key(48'h4848_0000_0000, 48'h4848_0000_0000, 32'h3232_0000, 32'h3232_0000,
                              16'h1600, 16'h1600, 5'd0)));
      checkOutput("mid_rst_resume_valid", 256'(key_valid_out0), 256'd1);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
